// File: rtl/sqrt_pkg.sv
// Shared definitions for the fixed-point square root unit.
//   iter_count : number of two-bit digit iterations for a given format
//   state_e    : controller states
//   params_ok  : legality of a WIDTH/FBITS/STEPS combination
package sqrt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    // Two radicand bits are retired per iteration.
    function automatic int iter_count(input int width, input int fbits);
        return (width + fbits) / 2;
    endfunction

    // Parameter legality check evaluated at elaboration.
    function automatic bit params_ok(input int width, input int fbits, input int steps);
        bit ok;
        ok = 1'b1;
        if (width < 2) ok = 1'b0;
        if (fbits < 0 || fbits > width) ok = 1'b0;
        if (((width + fbits) % 2) != 0) ok = 1'b0;
        if (steps < 1) ok = 1'b0;
        else if ((iter_count(width, fbits) % steps) != 0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit iteration of the binary square root.
//   rem_i   : partial remainder (WIDTH+1 bits)
//   root_i  : partial root
//   bits_i  : next two radicand bits, MSB first
//   rem_o   : updated remainder
//   root_o  : updated root (one more result bit appended)
module sqrt_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] root_i,
    input  logic [1:0]       bits_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] root_o
);

    // Trial value needs two extra bits over the remainder before subtraction.
    localparam int TW = WIDTH + 3;

    logic [TW-1:0] trial_s;
    logic [TW-1:0] test_s;
    logic          ge_s;

    assign trial_s = {rem_i, bits_i};
    assign test_s  = {1'b0, root_i, 2'b01};
    assign ge_s    = (trial_s >= test_s);

    // Subtract 4*root+1 when it fits; the result bit is the comparison outcome.
    // The remainder never exceeds 2*root, so the narrowing casts are lossless.
    always_comb begin
        rem_o  = '0;
        root_o = WIDTH'({root_i, ge_s});
        if (ge_s) begin
            rem_o = (WIDTH+1)'(trial_s - test_s);
        end else begin
            rem_o = (WIDTH+1)'(trial_s);
        end
    end

endmodule

// File: rtl/square_root_fx.sv
// Iterative unsigned fixed-point square root, STEPS digit iterations per clock.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, aborts a calculation in flight
//   start : request; accepted only while busy=0
//   rad   : radicand UQ(WIDTH-FBITS).FBITS, captured with an accepted start
//   busy  : calculation in progress
//   valid : one-cycle pulse when root/rem update
//   root  : floor(sqrt(rad << FBITS)), UQ(WIDTH-FBITS).FBITS
//   rem   : (rad << FBITS) - root^2
module square_root_fx
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 0,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH:0]   rem
);

    localparam int ITER = iter_count(WIDTH, FBITS);
    localparam int XW   = WIDTH + FBITS;
    localparam int N    = ITER / STEPS;
    localparam int CW   = $clog2(N + 1);

    if (!params_ok(WIDTH, FBITS, STEPS)) begin : g_param_check
        $fatal(1, "square_root_fx: illegal WIDTH/FBITS/STEPS combination");
    end

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [XW-1:0]    x_q;
    logic [XW-1:0]    x_d;
    logic [WIDTH:0]   prem_q;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] proot_q;
    logic [WIDTH-1:0] root_d;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] root_q;
    logic [WIDTH:0]   rem_q;

    logic [WIDTH:0]   rem_c  [STEPS+1];
    logic [WIDTH-1:0] root_c [STEPS+1];

    assign rem_c[0]  = prem_q;
    assign root_c[0] = proot_q;

    // Combinational chain: stage s consumes the s-th bit pair from the top of x_q.
    for (genvar s = 0; s < STEPS; s++) begin : g_step
        sqrt_step #(.WIDTH(WIDTH)) u_step (
            .rem_i  (rem_c[s]),
            .root_i (root_c[s]),
            .bits_i (x_q[XW-1-2*s -: 2]),
            .rem_o  (rem_c[s+1]),
            .root_o (root_c[s+1])
        );
    end

    assign rem_d  = rem_c[STEPS];
    assign root_d = root_c[STEPS];
    assign x_d    = x_q << (2 * STEPS);

    assign busy  = busy_q;
    assign valid = valid_q;
    assign root  = root_q;
    assign rem   = rem_q;

    // Controller and datapath registers; results only update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            prem_q  <= '0;
            proot_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        x_q     <= XW'(rad) << FBITS;
                        prem_q  <= '0;
                        proot_q <= '0;
                        cnt_q   <= CW'(N);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    x_q     <= x_d;
                    prem_q  <= rem_d;
                    proot_q <= root_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        root_q  <= root_d;
                        rem_q   <= rem_d;
                        state_q <= IDLE;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_root_fx.sv
// Self-checking bench: six WIDTH=8 instances with different FBITS/STEPS,
// directed handshake/reset scenarios and a shuffled sweep of all radicands
// against an integer square-root reference model.
module tb_square_root_fx;

    localparam int NI = 6;

    // Instance g configuration: (FBITS, STEPS)
    function automatic int fb_of(input int g);
        case (g)
            0: return 0;
            1: return 0;
            2: return 4;
            3: return 4;
            4: return 8;
            5: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int st_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 1;
            3: return 2;
            4: return 4;
            5: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        return ((8 + fb_of(g)) / 2) / st_of(g);
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [NI];
    logic [7:0] rad_s   [NI];
    logic       busy_s  [NI];
    logic       valid_s [NI];
    logic [7:0] root_s  [NI];
    logic [8:0] rem_s   [NI];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        square_root_fx #(.WIDTH(8), .FBITS(fb_of(g)), .STEPS(st_of(g))) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_s[g]),
            .rad   (rad_s[g]),
            .busy  (busy_s[g]),
            .valid (valid_s[g]),
            .root  (root_s[g]),
            .rem   (rem_s[g])
        );
    end

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer floor square root of R << FBITS.
    task automatic ref_sqrt(input int fb, input int v, output longint r, output longint m);
        longint x;
        x = longint'(v) << fb;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        m = x - r * r;
    endtask

    // Counts edges after acceptance until valid; flags cycles where busy drops early.
    task automatic wait_valid(input int g, output int cnt, output int bad_busy);
        bit seen;
        cnt = 0;
        bad_busy = 0;
        seen = 1'b0;
        while (!seen && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (valid_s[g]) seen = 1'b1;
            else if (!busy_s[g]) bad_busy++;
        end
        check_value("valid_seen", longint'(seen), 1);
    endtask

    task automatic run_calc(input int g, input logic [7:0] v,
                            output longint r, output longint m, output int lat);
        int bad;
        @(negedge clk);
        start_s[g] = 1'b1;
        rad_s[g]   = v;
        @(posedge clk);
        #1;
        start_s[g] = 1'b0;
        rad_s[g]   = 8'($urandom);
        check_value("busy_after_start", longint'(busy_s[g]), 1);
        wait_valid(g, lat, bad);
        check_value("busy_during_calc", bad, 0);
        check_value("busy_at_valid", longint'(busy_s[g]), 0);
        r = longint'(root_s[g]);
        m = longint'(rem_s[g]);
    endtask

    initial begin
        longint r, m, er, em;
        int lat, bad, pulses;
        int perm [256];
        int dir_rad  [5] = '{0, 1, 121, 90, 255};
        int dir_root [5] = '{0, 1, 11, 9, 15};
        int dir_rem  [5] = '{0, 0, 0, 9, 30};

        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            rad_s[i]   = 8'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_value("reset_busy",  longint'(busy_s[i]),  0);
            check_value("reset_valid", longint'(valid_s[i]), 0);
            check_value("reset_root",  longint'(root_s[i]),  0);
            check_value("reset_rem",   longint'(rem_s[i]),   0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Integer format, one iteration per clock.
        for (int i = 0; i < 5; i++) begin
            run_calc(0, 8'(dir_rad[i]), r, m, lat);
            check_value("dir_root", r, dir_root[i]);
            check_value("dir_rem", m, dir_rem[i]);
            check_value("dir_lat", lat, 4);
        end

        // Fractional formats.
        run_calc(3, 8'h20, r, m, lat);
        check_value("q44_2_root", r, 'h16);
        check_value("q44_2_rem", m, 28);
        check_value("q44_2_lat", lat, 3);
        run_calc(3, 8'h90, r, m, lat);
        check_value("q44_9_root", r, 'h30);
        check_value("q44_9_rem", m, 0);
        run_calc(4, 8'hFF, r, m, lat);
        check_value("q08_root", r, 'hFF);
        check_value("q08_rem", m, 255);
        check_value("q08_lat", lat, 2);

        // start while busy is ignored; start on the valid cycle is accepted.
        @(negedge clk);
        start_s[0] = 1'b1;
        rad_s[0]   = 8'd121;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        rad_s[0]   = 8'd9;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        wait_valid(0, lat, bad);
        check_value("ignore_lat", lat, 2);
        check_value("ignore_root", longint'(root_s[0]), 11);
        start_s[0] = 1'b1;
        rad_s[0]   = 8'd81;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        check_value("b2b_valid_drop", longint'(valid_s[0]), 0);
        check_value("b2b_busy", longint'(busy_s[0]), 1);
        wait_valid(0, lat, bad);
        check_value("b2b_lat", lat, 4);
        check_value("b2b_root", longint'(root_s[0]), 9);
        check_value("b2b_rem", longint'(rem_s[0]), 0);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (valid_s[0]) pulses++;
        end
        check_value("no_extra_valid", pulses, 0);

        // Reset aborts a calculation in flight.
        @(negedge clk);
        start_s[0] = 1'b1;
        rad_s[0]   = 8'd255;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("abort_busy",  longint'(busy_s[0]),  0);
        check_value("abort_valid", longint'(valid_s[0]), 0);
        check_value("abort_root",  longint'(root_s[0]),  0);
        check_value("abort_rem",   longint'(rem_s[0]),   0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (valid_s[0]) pulses++;
        end
        check_value("abort_no_valid", pulses, 0);
        run_calc(0, 8'd81, r, m, lat);
        check_value("after_abort_root", r, 9);
        check_value("after_abort_rem", m, 0);

        // Shuffled sweep of every radicand on every configuration.
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 256; i++) perm[i] = i;
            for (int i = 255; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(i, 0));
                t = perm[i];
                perm[i] = perm[j];
                perm[j] = t;
            end
            for (int i = 0; i < 256; i++) begin
                run_calc(g, 8'(perm[i]), r, m, lat);
                ref_sqrt(fb_of(g), perm[i], er, em);
                check_value("sweep_root", r, er);
                check_value("sweep_rem", m, em);
                check_value("sweep_lat", lat, lat_of(g));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
